// File: rtl/mmio_port_responder.sv
// MMIO responder: synchronized input port with change flag, and an output FIFO drained over PortValid/PortReady.
// Reads are combinational; a push is visible on PortOut one edge later; a full FIFO drops pushes. Optional MMIO_PORT_IRQ_EN adds Irq.
module mmio_port_responder #(
  parameter int          DATA_WIDTH = 32,
  parameter int          IN_WIDTH   = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Hit,
  input  logic [IN_WIDTH-1:0]   PortIn,
  output logic [DATA_WIDTH-1:0] PortOut,
  output logic                  PortValid,
`ifdef MMIO_PORT_IRQ_EN
  input  logic                  PortReady,
  output logic                  Irq
`else
  input  logic                  PortReady
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]            offset;
  logic                  wr_out, wr_status, wr_ctrl, rd_in;
  logic                  full, empty, pop, do_push, ovf_set;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] last_push;
  logic                  overflow, drain_en;
  logic [IN_WIDTH-1:0]   in_meta, in_sync, in_prev;
  logic                  in_changed;
  logic [DATA_WIDTH-1:0] status, ctrl;
  logic                  unused_addr;

  assign offset      = Address[3:2];
  assign unused_addr = ^Address[1:0];
  assign Hit         = (Address[31:4] == BASE_ADDR[31:4]);
  assign wr_out      = Hit & MemWrite & (offset == 2'd0);
  assign wr_status   = Hit & MemWrite & (offset == 2'd1);
  assign wr_ctrl     = Hit & MemWrite & (offset == 2'd3);
  assign rd_in       = Hit & MemRead  & (offset == 2'd2);

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign PortValid = ~empty & drain_en;
  assign pop       = PortValid & PortReady;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = wr_out & (~full | pop);
  assign ovf_set   = wr_out & full & ~pop;
  assign PortOut   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_push <= '0;
      overflow  <= 1'b0;
      drain_en  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_out) last_push <= WriteData;
      if (ovf_set)                       overflow <= 1'b1;
      else if (wr_status & WriteData[3]) overflow <= 1'b0;
      if (wr_ctrl) drain_en <= WriteData[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_meta    <= '0;
      in_sync    <= '0;
      in_prev    <= '0;
      in_changed <= 1'b0;
    end else begin
      in_meta <= PortIn;
      in_sync <= in_meta;
      in_prev <= in_sync;
      // A fresh change outranks a clearing read in the same cycle.
      if (in_sync != in_prev) in_changed <= 1'b1;
      else if (rd_in)         in_changed <= 1'b0;
    end
  end

`ifdef MMIO_PORT_IRQ_EN
  logic irq_en, drained, was_empty, irq_q, drain_pulse;

  assign drain_pulse = empty & ~was_empty;
  assign Irq         = irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en    <= 1'b0;
      drained   <= 1'b0;
      was_empty <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= WriteData[1];
      if (drain_pulse)                   drained <= 1'b1;
      else if (wr_status & WriteData[9]) drained <= 1'b0;
      was_empty <= empty;
      irq_q     <= irq_en & (in_changed | overflow | drain_pulse);
    end
  end
`endif

  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = in_changed;
    status[3]   = overflow;
    status[8:4] = 5'(count);
    ctrl        = '0;
    ctrl[0]     = drain_en;
`ifdef MMIO_PORT_IRQ_EN
    status[9]   = drained;
    ctrl[1]     = irq_en;
`endif
    ReadData = '0;
    if (Hit & MemRead & reset) begin
      case (offset)
        2'd0:    ReadData = last_push;
        2'd1:    ReadData = status;
        2'd2:    ReadData = DATA_WIDTH'(in_sync);
        default: ReadData = ctrl;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: register-access tables plus hand sequences; PortOut checked by a scoreboard queue.
module tb_mmio_port_responder;

  localparam logic [31:0] A_OUT  = 32'h1001_0000;
  localparam logic [31:0] A_STAT = 32'h1001_0004;
  localparam logic [31:0] A_IN   = 32'h1001_0008;
  localparam logic [31:0] A_CTRL = 32'h1001_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write, mem_read;
  logic [31:0] address, write_data, read_data;
  logic        hit;
  logic [7:0]  port_in;
  logic [31:0] port_out;
  logic        port_valid, port_ready;

  always #5 clk = ~clk;

  mmio_port_responder dut (
    .clk       (clk),
    .reset     (rst_n),
    .MemWrite  (mem_write),
    .MemRead   (mem_read),
    .Address   (address),
    .WriteData (write_data),
    .ReadData  (read_data),
    .Hit       (hit),
    .PortIn    (port_in),
    .PortOut   (port_out),
    .PortValid (port_valid),
    .PortReady (port_ready)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    logic        land;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                     input logic land, input string name);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.chk = chk; v.exp = exp; v.land = land; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus cycle held across a rising edge; ReadData sampled before the edge.
  task automatic apply(input vec_t v);
    mem_write  = v.wr;
    mem_read   = v.rd;
    address    = v.addr;
    write_data = v.wdata;
    if (v.wr && v.land) sb.push_back(v.wdata);
    #1;
    if (v.chk) check(v.name, read_data, v.exp);
    step();
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  // Combinational read that is released before the next edge.
  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
    address  = addr;
    mem_read = 1'b1;
    #1;
    check(name, read_data, exp);
    mem_read = 1'b0;
  endtask

  task automatic wait_sb_empty(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check(name, 32'(sb.size()), 32'h0);
  endtask

  always @(negedge clk) begin
    logic [31:0] head;
    #3;
    if (port_valid === 1'b1 && port_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra actual=%h required=no_transfer", port_out);
      end else begin
        head = sb.pop_front();
        check("port_out", port_out, head);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; mem_write = 1'b0; mem_read = 1'b0; address = '0;
    write_data = '0; port_in = '0; port_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'b0, port_valid}, 32'h0);
    check("rst_portout", port_out, 32'h0);

    // Reset values, fill to full, overflow on a fifth write.
    add(0, 1, A_STAT, 0, 1, 32'h0000_0002, 0, "rst_status");
    add(0, 1, A_CTRL, 0, 1, 32'h0000_0001, 0, "rst_ctrl");
    add(0, 1, A_OUT,  0, 1, 32'h0000_0000, 0, "rst_last_push");
    for (int i = 1; i <= 4; i++) add(1, 0, A_OUT, 32'hAAAA_0000 + i, 0, 0, 1, "fill");
    add(0, 1, A_OUT,  0, 1, 32'hAAAA_0004, 0, "last_push");
    add(0, 1, A_STAT, 0, 1, 32'h0000_0041, 0, "full_status");
    add(1, 0, A_OUT,  32'hDEAD_BEEF, 0, 0, 0, "overflow_write");
    add(0, 1, A_STAT, 0, 1, 32'h0000_0049, 0, "ovf_status");
    run_tbl();
    #1;
    check("fill_valid", {31'b0, port_valid}, 32'h1);
    check("fill_head", port_out, 32'hAAAA_0001);

    // Drain four words, one per edge.
    port_ready = 1'b1;
    repeat (4) step();
    port_ready = 1'b0;
    #1;
    check("drained_valid", {31'b0, port_valid}, 32'h0);
    check("drained_portout", port_out, 32'h0);
    add(0, 1, A_STAT, 0, 1, 32'h0000_000A, 0, "empty_ovf_status");
    add(1, 0, A_STAT, 32'h8, 0, 0, 0, "clear_ovf");
    add(0, 1, A_STAT, 0, 1, 32'h0000_0002, 0, "cleared_status");
    for (int i = 1; i <= 4; i++) add(1, 0, A_OUT, 32'hB000_0000 + i, 0, 0, 1, "refill");
    run_tbl();

    // Push and pop together while full.
    port_ready = 1'b1;
    add(1, 0, A_OUT, 32'h0000_0005, 0, 0, 1, "push_pop_full");
    run_tbl();
    port_ready = 1'b0;
    rd_chk(A_STAT, 32'h0000_0041, "push_pop_status");
    port_ready = 1'b1;
    wait_sb_empty("push_pop_drain");
    port_ready = 1'b0;
    rd_chk(A_STAT, 32'h0000_0002, "push_pop_empty");

    // drain_en=0 holds the word; simultaneous read+write returns the old CTRL.
    add(1, 0, A_OUT,  32'hC000_0001, 0, 0, 1, "hold_push");
    add(1, 1, A_CTRL, 32'h0, 1, 32'h0000_0001, 0, "rw_ctrl_pre");
    add(0, 1, A_CTRL, 0, 1, 32'h0000_0000, 0, "ctrl_off");
    run_tbl();
    port_ready = 1'b1;
    step();
    step();
    #1;
    check("hold_valid", {31'b0, port_valid}, 32'h0);
    check("hold_portout", port_out, 32'hC000_0001);
    add(1, 0, A_CTRL, 32'h1, 0, 0, 0, "ctrl_on");
    run_tbl();
    wait_sb_empty("hold_drain");
    port_ready = 1'b0;

    // Input path: change appears in STATUS.bit2 after three edges.
    port_in = 8'h3C;
    step(); rd_chk(A_STAT, 32'h0000_0002, "in_edge1");
    step(); rd_chk(A_STAT, 32'h0000_0002, "in_edge2");
    step(); rd_chk(A_STAT, 32'h0000_0006, "in_edge3");
    add(0, 1, A_IN, 0, 1, 32'h0000_003C, 0, "in_data");
    run_tbl();
    rd_chk(A_STAT, 32'h0000_0002, "in_cleared");
    port_in = 8'h3D;
    step();
    step();
    add(0, 1, A_IN, 0, 1, 32'h0000_003D, 0, "in_data_collide");
    run_tbl();
    rd_chk(A_STAT, 32'h0000_0006, "in_set_wins");
    add(0, 1, A_IN, 0, 1, 32'h0000_003D, 0, "in_data_again");
    run_tbl();
    rd_chk(A_STAT, 32'h0000_0002, "in_cleared2");

    // Asynchronous reset in the middle of a drain.
    add(1, 0, A_OUT, 32'hD000_0001, 0, 0, 1, "rst_push1");
    add(1, 0, A_OUT, 32'hD000_0002, 0, 0, 1, "rst_push2");
    run_tbl();
    port_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, port_valid}, 32'h0);
    check("async_rst_portout", port_out, 32'h0);
    sb.delete();
    rd_chk(A_STAT, 32'h0000_0000, "rd_in_reset");
    port_ready = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    rd_chk(A_STAT, 32'h0000_0002, "post_rst_status");
    check("hit_inside", {31'b0, hit}, 32'h1);
    rd_chk(32'h1001_0010, 32'h0000_0000, "outside_read");
    check("hit_outside", {31'b0, hit}, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
